fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP bubble word and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no request outstanding
    WAIT = 2'd1,   // request outstanding, response will be kept
    DROP = 2'd2    // request outstanding, response will be discarded
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned FIFO_W           = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of {pc+4, instr} entries with synchronous
// flush and asynchronous active-high reset. FIFO_DEPTH must be a power of two
// so the pointers wrap naturally.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = FIFO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == DEPTH_C);
  assign empty  = (r_cnt == '0);
  assign rdata  = r_mem[r_rd];
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding-request memory FSM, prefetch
// FIFO and decode-stage register. Optional performance counters are enabled
// by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_drop_cnt
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic [31:0]  w_pc_plus4;
  logic         w_issue;
  logic         w_accept;
  logic         w_discard;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [63:0]  w_head;
  logic [31:0]  r_instr_d;
  logic [31:0]  r_pcplus4_d;
  logic         r_valid_d;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state logic; a zero-wait ack in the issue cycle completes in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!redirect && !w_full) begin
          w_issue = 1'b1;
          if (imem_ack) w_accept    = 1'b1;
          else          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          if (redirect) w_discard = 1'b1;
          else          w_accept  = 1'b1;
        end else if (redirect) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          w_discard   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request is gated by rst so it drops immediately on reset assertion.
  assign imem_req  = ~rst & (w_issue | (r_state != IDLE));
  assign imem_addr = (r_state == IDLE) ? r_pc : r_addr;

  // An empty FIFO with the decoder free lets the response skip the buffer,
  // giving one-cycle ack-to-decode latency.
  assign w_bypass = w_accept & ~stallD & w_empty;
  assign w_push   = w_accept & ~w_bypass;
  assign w_pop    = ~redirect & ~stallD & ~w_empty;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC and latched request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      if (redirect)      r_pc <= redirect_pc;
      else if (w_accept) r_pc <= w_pc_plus4;
      if (w_issue) r_addr <= r_pc;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata ({w_pc_plus4, imem_rdata}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Decode register: redirect clears, stall holds, else pop/bypass/bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d   <= NOP;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (redirect) begin
      r_instr_d   <= NOP;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!stallD) begin
      if (!w_empty) begin
        r_pcplus4_d <= w_head[63:32];
        r_instr_d   <= w_head[31:0];
        r_valid_d   <= 1'b1;
      end else if (w_bypass) begin
        r_pcplus4_d <= w_pc_plus4;
        r_instr_d   <= imem_rdata;
        r_valid_d   <= 1'b1;
      end else begin
        r_instr_d   <= NOP;
        r_valid_d   <= 1'b0;
      end
    end
  end

  assign instrD   = r_instr_d;
  assign pcplus4D = r_pcplus4_d;
  assign validD   = r_valid_d;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [15:0] r_perf_drop;

  // Saturating counters of accepted and discarded responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_accept && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_discard && (r_perf_drop != '1)) r_perf_drop  <= r_perf_drop + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`else
  logic unused_perf;
  assign unused_perf = w_discard;
`endif

endmodule
